// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, digit-count
// helpers and a parameter-legality check usable at module scope.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Elaboration-time guard: WIDTH must be a positive multiple of DIGIT.
// Expands to a generate-if, so it must be used at module item level.
`define ADDER_CHECK_PARAMS(W, D) \
   if (((D) < 1) || ((D) > (W)) || (((W) % (D)) != 0)) begin : g_illegal_params \
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT"); \
   end

package adder_pkg;

   // Operation sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of DIGIT-wide slices in a WIDTH-bit operand
   function automatic int n_digits(input int width, input int digit);
      return (digit > 0) ? (width / digit) : 1;
   endfunction

   // Digit counter width; at least one bit even when a single digit is used
   function automatic int cnt_width(input int width, input int digit);
      int n;
      n = n_digits(width, digit);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`endif

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice built from full-adder cells.
// Besides the carry out of the slice it exposes the carry into its MSB,
// which the top level needs to form signed overflow on the last digit.
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_c,
   output logic [DIGIT-1:0] o_s,
   output logic             o_c,
   output logic             o_c_msb
);

   // w_c[k] is the carry into bit k; w_c[DIGIT] leaves the slice
   logic [DIGIT:0] w_c;

   assign w_c[0] = i_c;

   // One full-adder cell per bit, chained through w_c
   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
      logic w_p;
      assign w_p         = i_a[gi] ^ i_b[gi];
      assign o_s[gi]     = w_p ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_p & w_c[gi]);
   end

   assign o_c     = w_c[DIGIT];
   assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are consumed DIGIT bits
// per clock through one shared digit_adder slice, with a registered carry
// linking consecutive digits. Valid/ready handshakes on both sides.
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   `ADDER_CHECK_PARAMS(WIDTH, DIGIT)

   localparam int N     = n_digits(WIDTH, DIGIT);
   localparam int CNT_W = cnt_width(WIDTH, DIGIT);
   localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;

   logic [DIGIT-1:0]   w_dig_s;
   logic               w_dig_c;
   logic               w_dig_c_msb;
   logic [WIDTH-1:0]   w_sum_shift;
   logic               w_accept;
   logic               w_busy;
   logic               w_last;

   // Shared digit slice always works on the low digit of the operand shifters
   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .i_a     (r_a[DIGIT-1:0]),
      .i_b     (r_b[DIGIT-1:0]),
      .i_c     (r_carry),
      .o_s     (w_dig_s),
      .o_c     (w_dig_c),
      .o_c_msb (w_dig_c_msb)
   );

   // New digits enter at the top of the sum register so that after N steps
   // the first digit has reached the bottom; a single-digit build just loads.
   if (DIGIT == WIDTH) begin : g_sum_load
      assign w_sum_shift = w_dig_s;
   end else begin : g_sum_shift
      assign w_sum_shift = {w_dig_s, r_sum[WIDTH-1:DIGIT]};
   end

   assign w_accept = in_valid && in_ready;
   assign w_busy   = (r_state == BUSY);
   assign w_last   = w_busy && (r_cnt == LAST_DIGIT);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs, decoded from the registered state
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == LAST_DIGIT) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Operand capture, digit-serial shifting, carry chaining and result flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         // Subtraction is a + ~b + ~borrow, so invert b and the carry-in here
         r_cnt   <= '0;
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_carry <= cin ^ sub;
      end else if (w_busy) begin
         r_cnt   <= r_cnt + 1'b1;
         r_a     <= r_a >> DIGIT;
         r_b     <= r_b >> DIGIT;
         r_sum   <= w_sum_shift;
         r_carry <= w_dig_c;
         if (w_last) begin
            r_cout <= w_dig_c;
            r_ovf  <= w_dig_c_msb ^ w_dig_c;
         end
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule
